// File: rtl/nes_cpu_pkg.sv
// Shared CPU constants and types.
// Vector addresses and vector sequencer state encoding.
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;

  localparam logic [MEM_ADDR_SIZE-1:0] NMI_VECTOR   = 16'hFFFA;
  localparam logic [MEM_ADDR_SIZE-1:0] RESET_VECTOR = 16'hFFFC;
  localparam logic [MEM_ADDR_SIZE-1:0] IRQ_VECTOR   = 16'hFFFE;

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    RUN,
    VEC_LO,
    VEC_HI,
    LOAD
  } vec_seq_state_e;

endpackage

// File: rtl/int_sync_edge.sv
// N-stage synchroniser for an async line.
// Provides the synchronised level and a one-cycle rising-edge pulse.
module int_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_q[0] <= async_i;
      prev_q    <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pc_vector_seq.sv
// PC sequencer: reset/NMI/IRQ vector fetch and branch forwarding.
// Freezes the PC by redirecting it to itself while a vector is fetched.
module pc_vector_seq
  import nes_cpu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [MEM_ADDR_SIZE-1:0] pc_i,
  input  logic                     branch_i,
  input  logic [MEM_ADDR_SIZE-1:0] branch_target_i,
  input  logic                     instr_boundary_i,
  input  logic                     irq_mask_i,
  input  logic                     nmi_i,
  input  logic                     irq_i,
  output logic                     mem_req_o,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [7:0]               mem_rdata_i,
  output logic                     taken_branch_o,
  output logic [MEM_ADDR_SIZE-1:0] new_pc_o,
  output logic                     stall_o,
  output logic                     int_ack_o,
  output logic                     int_is_nmi_o,
  output logic [MEM_ADDR_SIZE-1:0] ret_pc_o
);

  vec_seq_state_e             state_q;
  logic [MEM_ADDR_SIZE-1:0]   base_q;
  logic [7:0]                 lo_q;
  logic [7:0]                 hi_q;
  logic                       pend_rd_q;
  logic                       nmi_pend_q;
  logic [SYNC_STAGES-1:0]     irq_sync_q;
  logic                       int_ack_q;
  logic                       int_nmi_q;
  logic [MEM_ADDR_SIZE-1:0]   ret_pc_q;

  logic nmi_rise;
  logic nmi_lvl;
  logic irq_lvl;
  logic fetch_lo;
  logic fetch_hi;
  logic fetching;
  logic accept;

  int_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_nmi_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (nmi_i),
    .level_o (nmi_lvl),
    .rise_o  (nmi_rise)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_sync_q <= '0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        irq_sync_q[i] <= irq_sync_q[i-1];
      end
      irq_sync_q[0] <= irq_i;
    end
  end

  assign irq_lvl  = irq_sync_q[SYNC_STAGES-1];
  assign fetch_lo = (state_q == RST_LO) | (state_q == VEC_LO);
  assign fetch_hi = (state_q == RST_HI) | (state_q == VEC_HI);
  assign fetching = fetch_lo | fetch_hi;

  assign accept = (state_q == RUN) & instr_boundary_i &
                  (nmi_pend_q | (irq_lvl & ~irq_mask_i));

  // one read in flight: request drops after grant until rvalid
  assign mem_req_o  = fetching & ~pend_rd_q;
  assign mem_addr_o = fetch_hi ? base_q + MEM_ADDR_SIZE'(1) : base_q;

  assign stall_o      = (state_q != RUN);
  assign int_ack_o    = int_ack_q;
  assign int_is_nmi_o = int_nmi_q;
  assign ret_pc_o     = ret_pc_q;

  always_comb begin
    taken_branch_o = 1'b1;
    new_pc_o       = pc_i;
    unique case (state_q)
      RUN: begin
        if (!accept) begin
          taken_branch_o = branch_i;
          new_pc_o       = branch_target_i;
        end
      end
      LOAD:    new_pc_o = {hi_q, lo_q};
      default: ;
    endcase
    if (!rstn_i) taken_branch_o = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RST_LO;
      base_q     <= RESET_VECTOR;
      lo_q       <= '0;
      hi_q       <= '0;
      pend_rd_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      int_ack_q  <= 1'b0;
      int_nmi_q  <= 1'b0;
      ret_pc_q   <= '0;
    end else begin
      int_ack_q  <= accept;
      int_nmi_q  <= accept & nmi_pend_q;
      nmi_pend_q <= nmi_rise | (nmi_pend_q & ~accept);
      if (mem_req_o && mem_gnt_i) begin
        pend_rd_q <= 1'b1;
      end else if (pend_rd_q && mem_rvalid_i) begin
        pend_rd_q <= 1'b0;
      end
      unique case (state_q)
        RUN: begin
          if (accept) begin
            ret_pc_q <= pc_i;
            base_q   <= nmi_pend_q ? NMI_VECTOR : IRQ_VECTOR;
            state_q  <= VEC_LO;
          end
        end
        RST_LO, VEC_LO: begin
          if (pend_rd_q && mem_rvalid_i) begin
            lo_q    <= mem_rdata_i;
            state_q <= (state_q == RST_LO) ? RST_HI : VEC_HI;
          end
        end
        RST_HI, VEC_HI: begin
          if (pend_rd_q && mem_rvalid_i) begin
            hi_q    <= mem_rdata_i;
            state_q <= LOAD;
          end
        end
        LOAD:    state_q <= RUN;
        default: state_q <= RST_LO;
      endcase
    end
  end

endmodule
